ram_ws: RTL and testbench

Parametrised byte-addressable data RAM for the MSP430 data space, successor to the fixed 512-byte RAM. It adds a request/ready handshake with configurable wait states, word-alignment enforcement and address-range error reporting. It also runs a hardware clear sequence after reset. It sits on the CPU memory bus beside ROM and peripherals, and is selected when the address falls in [BOUND_L, BOUND_U).

---
 rtl/ram_ws.sv | 123 ++++++++++++
 tb/tb_ram_ws.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/ram_ws.sv
// ram_ws: byte-addressable data RAM with wait states, range errors and post-reset clear
module ram_ws #(
  parameter logic [15:0] BOUND_L        = 16'h0200,
  parameter logic [15:0] BOUND_U        = 16'h0400,
  parameter int          WAIT_STATES    = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ram_req,
  input  logic [15:0] ram_addr,
  input  logic [15:0] ram_Din,
  input  logic        ram_RW,
  input  logic        BW,
  output logic [15:0] ram_out,
  output logic        ram_ready,
  output logic        ram_err,
  output logic        ram_busy
);
  localparam int SIZE = int'(BOUND_U) - int'(BOUND_L);
  localparam int AW   = $clog2(SIZE);
  localparam int CW   = (AW > 1) ? AW - 1 : 1;
  typedef enum logic [1:0] {CLEAR, IDLE, WAIT, DONE} state_t;
  localparam state_t RST_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;
  state_t        state_q, state_d;
  logic [CW-1:0] clr_q, clr_d;
  logic [2:0]    wcnt_q, wcnt_d;
  logic [15:0]   addr_q, din_q, out_q, out_d;
  logic          rw_q, bw_q, err_q;
  logic [7:0]    mem [SIZE];
  logic [15:0]   a_addr, a_din, aln;
  logic          a_rw, a_bw, in_rng, commit;
  logic [AW-1:0] idx, lo, hi;
  // Access fields come straight from the bus on the IDLE edge, from the latched copy afterwards
  always_comb begin
    a_addr = (state_q == IDLE) ? ram_addr : addr_q;
    a_din  = (state_q == IDLE) ? ram_Din  : din_q;
    a_rw   = (state_q == IDLE) ? ram_RW   : rw_q;
    a_bw   = (state_q == IDLE) ? BW       : bw_q;
    aln    = a_bw ? a_addr : {a_addr[15:1], 1'b0};
    in_rng = (aln >= BOUND_L) && (aln < BOUND_U);
    idx    = AW'(aln - BOUND_L);
    lo     = a_bw ? idx : {idx[AW-1:1], 1'b0};
    hi     = {idx[AW-1:1], 1'b1};
    out_d  = !in_rng ? 16'h0000 :
             a_rw    ? (a_bw ? {8'h00, a_din[7:0]} : a_din) :
                       (a_bw ? {8'h00, mem[lo]} : {mem[hi], mem[lo]});
  end
  // Next-state logic; commit marks the edge that enters DONE
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    wcnt_d  = wcnt_q;
    commit  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_d   = clr_q + 1'b1;
        state_d = (clr_q == CW'(SIZE / 2 - 1)) ? IDLE : CLEAR;
      end
      IDLE: if (ram_req) begin
        if (WAIT_STATES == 0) begin
          state_d = DONE;
          commit  = 1'b1;
        end else begin
          state_d = WAIT;
          wcnt_d  = 3'(WAIT_STATES - 1);
        end
      end
      WAIT: begin
        if (!ram_req) state_d = IDLE;
        else if (wcnt_q == 3'd0) begin
          state_d = DONE;
          commit  = 1'b1;
        end else wcnt_d = wcnt_q - 3'd1;
      end
      DONE: state_d = IDLE;
    endcase
  end
  // Control state, request latch and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      clr_q   <= '0;
      wcnt_q  <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      rw_q    <= 1'b0;
      bw_q    <= 1'b0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      wcnt_q  <= wcnt_d;
      if (state_q == IDLE && ram_req) begin
        addr_q <= ram_addr;
        din_q  <= ram_Din;
        rw_q   <= ram_RW;
        bw_q   <= BW;
      end
      if (commit) begin
        out_q <= out_d;
        err_q <= !in_rng;
      end
    end
  end
  // Storage array: clear one word per cycle, else commit in-range writes; nothing lands while in reset
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == CLEAR) begin
        mem[{clr_q, 1'b0}] <= 8'h00;
        mem[{clr_q, 1'b1}] <= 8'h00;
      end else if (commit && a_rw && in_rng) begin
        mem[lo] <= a_din[7:0];
        if (!a_bw) mem[hi] <= a_din[15:8];
      end
    end
  end
  assign ram_out   = out_q;
  assign ram_err   = err_q;
  assign ram_ready = (state_q == DONE);
  assign ram_busy  = (state_q == CLEAR);
endmodule

// File: tb/tb_ram_ws.sv
// tb_ram_ws: scoreboard bench for ram_ws with zero and three wait-state instances
module tb_ram_ws;
  typedef struct {
    int          d;
    logic [15:0] out;
    logic        err;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req [2];
  logic [15:0] addr [2];
  logic [15:0] din [2];
  logic        rw [2];
  logic        bw [2];
  logic [15:0] out [2];
  logic        rdy [2];
  logic        err [2];
  logic        busy [2];
  exp_t        sbq [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  ram_ws #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ram_req(req[0]), .ram_addr(addr[0]), .ram_Din(din[0]),
    .ram_RW(rw[0]), .BW(bw[0]), .ram_out(out[0]), .ram_ready(rdy[0]), .ram_err(err[0]),
    .ram_busy(busy[0]));
  ram_ws #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .ram_req(req[1]), .ram_addr(addr[1]), .ram_Din(din[1]),
    .ram_RW(rw[1]), .BW(bw[1]), .ram_out(out[1]), .ram_ready(rdy[1]), .ram_err(err[1]),
    .ram_busy(busy[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req_v);
    end
  endtask

  // monitor: every ready pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rdy[d] === 1'b1) begin
        if (sbq.size() == 0) chk($sformatf("unexpected_ready_dut%0d", d), 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sbq.pop_front();
          chk("resp_dut", d, e.d);
          chk($sformatf("ram_out_dut%0d", d), {16'h0, out[d]}, {16'h0, e.out});
          chk($sformatf("ram_err_dut%0d", d), {31'h0, err[d]}, {31'h0, e.err});
        end
      end
    end
  end

  task automatic acc(input int d, input logic [15:0] a, input logic [15:0] dv, input logic rwv,
                     input logic bwv, input logic [15:0] eo, input logic ee, input int elat);
    int lat;
    sbq.push_back('{d, eo, ee});
    addr[d] = a; din[d] = dv; rw[d] = rwv; bw[d] = bwv; req[d] = 1'b1;
    @(posedge clk);
    lat = 0;
    while (1) begin
      #1 lat++;
      if (rdy[d] === 1'b1 || lat > 20) break;
      @(posedge clk);
    end
    chk($sformatf("latency_dut%0d_%h", d, a), lat, elat);
    req[d] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clear(input string name);
    int n;
    n = 0;
    while ((busy[0] === 1'b1 || busy[1] === 1'b1) && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk(name, n, 256);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; addr[d] = '0; din[d] = '0; rw[d] = 1'b0; bw[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_out", {out[0], out[1]}, 32'h0);
    chk("rst_ready_err", {28'h0, rdy[0], rdy[1], err[0], err[1]}, 32'h0);
    chk("rst_busy", {30'h0, busy[0], busy[1]}, 32'h3);
    rst_n = 1'b1;
    wait_clear("busy_cycles");
    acc(0, 16'h03FE, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1);
    acc(0, 16'h0200, 16'h1234, 1'b1, 1'b0, 16'h1234, 1'b0, 1);
    acc(0, 16'h0201, 16'h0000, 1'b0, 1'b1, 16'h0012, 1'b0, 1);
    acc(0, 16'h0200, 16'hAB77, 1'b1, 1'b1, 16'h0077, 1'b0, 1);
    acc(0, 16'h0200, 16'h0000, 1'b0, 1'b0, 16'h1277, 1'b0, 1);
    acc(0, 16'h0203, 16'hBEEF, 1'b1, 1'b0, 16'hBEEF, 1'b0, 1);
    acc(0, 16'h0202, 16'h0000, 1'b0, 1'b1, 16'h00EF, 1'b0, 1);
    acc(0, 16'h0203, 16'h0000, 1'b0, 1'b1, 16'h00BE, 1'b0, 1);
    acc(0, 16'h0203, 16'hAA55, 1'b1, 1'b1, 16'h0055, 1'b0, 1);
    acc(0, 16'h0202, 16'h0000, 1'b0, 1'b0, 16'h55EF, 1'b0, 1);
    acc(0, 16'h03FE, 16'hC0DE, 1'b1, 1'b0, 16'hC0DE, 1'b0, 1);
    acc(0, 16'h0400, 16'h1111, 1'b1, 1'b0, 16'h0000, 1'b1, 1);
    acc(0, 16'h01FF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1);
    acc(0, 16'h03FE, 16'h0000, 1'b0, 1'b0, 16'hC0DE, 1'b0, 1);
    acc(1, 16'h0300, 16'h1357, 1'b1, 1'b0, 16'h1357, 1'b0, 4);
    acc(1, 16'h0300, 16'h0000, 1'b0, 1'b0, 16'h1357, 1'b0, 4);
    begin
      int nr;
      nr = 0;
      addr[1] = 16'h0300; din[1] = 16'h5A5A; rw[1] = 1'b1; bw[1] = 1'b0; req[1] = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 req[1] = 1'b0;
      repeat (8) begin
        @(posedge clk);
        #1 if (rdy[1] === 1'b1) nr++;
      end
      chk("abort_no_ready", nr, 0);
    end
    acc(1, 16'h0300, 16'h0000, 1'b0, 1'b0, 16'h1357, 1'b0, 4);
    addr[1] = 16'h0300; din[1] = 16'h2468; rw[1] = 1'b1; bw[1] = 1'b0; req[1] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_out", {out[0], out[1]}, 32'h0);
    chk("midrst_ready_err", {28'h0, rdy[0], rdy[1], err[0], err[1]}, 32'h0);
    chk("midrst_busy", {30'h0, busy[0], busy[1]}, 32'h3);
    req[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear("busy_cycles_rerun");
    acc(1, 16'h0300, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 4);
    acc(0, 16'h0200, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1);
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
